// File: rtl/cordic_scheduler.sv
// ----------------------------------------------------------------------------
// cordic_scheduler
//
// Shares one pipelined CORDIC core between NUM_CH requesters. A round-robin
// arbiter grants at most one channel per cycle while running, the granted
// sample is registered onto the CORDIC operand bus, and a tag shift register
// travelling alongside the core remembers which channel each operand belongs
// to so the result can be steered back with a one-hot strobe.
//
// Ports
//   clock, reset         rising-edge clock, asynchronous active-low reset
//   enable               run request (IDLE -> RUN, RUN -> DRAIN when low)
//   ch_mask              per-channel grant enable
//   req_valid/req_ready  per-channel sample handshake (req_ready is one-hot)
//   req_x/req_y/req_z    packed per-channel samples, channel k in slice k
//   cordic_xin/yin/zin   operands to the CORDIC core (zero on bubbles)
//   cordic_xout/yout/zout results from the core, CORDIC_LATENCY cycles later
//   res_valid            one-hot result strobe
//   res_x/res_y/res_z    result data, held while res_valid is zero
//   busy                 state is not IDLE
//   in_flight            operations issued but not yet delivered
// ----------------------------------------------------------------------------
module cordic_scheduler #(
  parameter int NUM_CH         = 4,
  parameter int XY_WIDTH       = 16,
  parameter int Z_INPUT_WIDTH  = 16,
  parameter int Z_OUTPUT_WIDTH = 5,
  parameter int CORDIC_LATENCY = 14
) (
  input  logic                                 clock,
  input  logic                                 reset,
  input  logic                                 enable,
  input  logic [NUM_CH-1:0]                    ch_mask,
  input  logic [NUM_CH-1:0]                    req_valid,
  output logic [NUM_CH-1:0]                    req_ready,
  input  logic [NUM_CH*XY_WIDTH-1:0]           req_x,
  input  logic [NUM_CH*XY_WIDTH-1:0]           req_y,
  input  logic [NUM_CH*Z_INPUT_WIDTH-1:0]      req_z,
  output logic signed [XY_WIDTH-1:0]           cordic_xin,
  output logic signed [XY_WIDTH-1:0]           cordic_yin,
  output logic [Z_INPUT_WIDTH-1:0]             cordic_zin,
  input  logic signed [XY_WIDTH-1:0]           cordic_xout,
  input  logic signed [XY_WIDTH-1:0]           cordic_yout,
  input  logic [Z_OUTPUT_WIDTH-1:0]            cordic_zout,
  output logic [NUM_CH-1:0]                    res_valid,
  output logic signed [XY_WIDTH-1:0]           res_x,
  output logic signed [XY_WIDTH-1:0]           res_y,
  output logic [Z_OUTPUT_WIDTH-1:0]            res_z,
  output logic                                 busy,
  output logic [$clog2(CORDIC_LATENCY+2)-1:0]  in_flight
);

  localparam int CH_W  = (NUM_CH > 1) ? $clog2(NUM_CH) : 1;
  localparam int IF_W  = $clog2(CORDIC_LATENCY + 2);
  // One extra stage covers the operand register in front of the core.
  localparam int DEPTH = CORDIC_LATENCY + 1;

  typedef enum logic [1:0] {IDLE, RUN, DRAIN} state_t;

  state_t                       state_q, state_d;
  logic [CH_W-1:0]              ptr_q, ptr_d;
  logic [IF_W-1:0]              in_flight_q, in_flight_d;
  logic signed [XY_WIDTH-1:0]   xin_q, xin_d, yin_q, yin_d;
  logic [Z_INPUT_WIDTH-1:0]     zin_q, zin_d;
  logic [DEPTH-1:0]             tag_vld_q, tag_vld_d;
  logic [CH_W-1:0]              tag_ch_q [DEPTH];
  logic [CH_W-1:0]              tag_ch_d [DEPTH];
  logic [NUM_CH-1:0]            res_valid_q, res_valid_d;
  logic signed [XY_WIDTH-1:0]   res_x_q, res_x_d, res_y_q, res_y_d;
  logic [Z_OUTPUT_WIDTH-1:0]    res_z_q, res_z_d;

  logic [NUM_CH-1:0]            eligible;
  logic [NUM_CH-1:0]            ready_c;
  logic [CH_W-1:0]              grant_idx;
  logic                         grant_any;
  logic                         transfer;
  logic                         tag_exit;
  logic [CH_W:0]                sum;
  logic [CH_W-1:0]              cand;

  assign eligible = req_valid & ch_mask;

  // FSM next state. DRAIN may return to RUN at any time; it only falls back
  // to IDLE once nothing is left in the pipe.
  always_comb begin
    state_d = state_q;
    unique case (state_q)
      IDLE:    if (enable) state_d = RUN;
      RUN:     if (!enable) state_d = DRAIN;
      DRAIN: begin
        if (enable)                   state_d = RUN;
        else if (in_flight_q == '0)   state_d = IDLE;
      end
      default: state_d = IDLE;
    endcase
  end

  // Round-robin search: ptr_q holds the first channel to consider, i.e. the
  // one after the last grant. The wrap is done by subtraction so that
  // non-power-of-two channel counts work.
  always_comb begin
    grant_idx = '0;
    grant_any = 1'b0;
    sum       = '0;
    cand      = '0;
    for (int i = 0; i < NUM_CH; i++) begin
      sum = {1'b0, ptr_q} + (CH_W+1)'(i);
      if (sum >= (CH_W+1)'(NUM_CH)) sum = sum - (CH_W+1)'(NUM_CH);
      cand = sum[CH_W-1:0];
      if (!grant_any && eligible[cand]) begin
        grant_any = 1'b1;
        grant_idx = cand;
      end
    end
    ready_c = '0;
    if (state_q == RUN && grant_any) ready_c[grant_idx] = 1'b1;
  end

  assign transfer  = (state_q == RUN) && grant_any;
  assign req_ready = ready_c;

  always_comb begin
    ptr_d = ptr_q;
    if (transfer) begin
      if (grant_idx == CH_W'(NUM_CH - 1)) ptr_d = '0;
      else                                ptr_d = grant_idx + CH_W'(1);
    end
  end

  // Operand capture; cycles without a transfer issue an all-zero bubble.
  always_comb begin
    xin_d = '0;
    yin_d = '0;
    zin_d = '0;
    if (transfer) begin
      for (int k = 0; k < NUM_CH; k++) begin
        if (grant_idx == CH_W'(k)) begin
          xin_d = req_x[k*XY_WIDTH +: XY_WIDTH];
          yin_d = req_y[k*XY_WIDTH +: XY_WIDTH];
          zin_d = req_z[k*Z_INPUT_WIDTH +: Z_INPUT_WIDTH];
        end
      end
    end
  end

  // Tag pipe: stage i lines up with the operand that entered the core i
  // cycles ago, so the last stage matches cordic_*out.
  always_comb begin
    tag_vld_d   = {tag_vld_q[DEPTH-2:0], transfer};
    tag_ch_d[0] = grant_idx;
    for (int i = 1; i < DEPTH; i++) tag_ch_d[i] = tag_ch_q[i-1];
  end

  assign tag_exit = tag_vld_q[DEPTH-1];

  always_comb begin
    res_valid_d = '0;
    res_x_d     = res_x_q;
    res_y_d     = res_y_q;
    res_z_d     = res_z_q;
    if (tag_exit) begin
      res_valid_d[tag_ch_q[DEPTH-1]] = 1'b1;
      res_x_d = cordic_xout;
      res_y_d = cordic_yout;
      res_z_d = cordic_zout;
    end
  end

  always_comb begin
    in_flight_d = in_flight_q;
    unique case ({transfer, tag_exit})
      2'b10:   in_flight_d = in_flight_q + IF_W'(1);
      2'b01:   in_flight_d = in_flight_q - IF_W'(1);
      default: in_flight_d = in_flight_q;
    endcase
  end

  always_ff @(posedge clock or negedge reset) begin
    if (!reset) begin
      state_q     <= IDLE;
      ptr_q       <= '0;
      in_flight_q <= '0;
      xin_q       <= '0;
      yin_q       <= '0;
      zin_q       <= '0;
      tag_vld_q   <= '0;
      for (int i = 0; i < DEPTH; i++) tag_ch_q[i] <= '0;
      res_valid_q <= '0;
      res_x_q     <= '0;
      res_y_q     <= '0;
      res_z_q     <= '0;
    end else begin
      state_q     <= state_d;
      ptr_q       <= ptr_d;
      in_flight_q <= in_flight_d;
      xin_q       <= xin_d;
      yin_q       <= yin_d;
      zin_q       <= zin_d;
      tag_vld_q   <= tag_vld_d;
      for (int i = 0; i < DEPTH; i++) tag_ch_q[i] <= tag_ch_d[i];
      res_valid_q <= res_valid_d;
      res_x_q     <= res_x_d;
      res_y_q     <= res_y_d;
      res_z_q     <= res_z_d;
    end
  end

  assign cordic_xin = xin_q;
  assign cordic_yin = yin_q;
  assign cordic_zin = zin_q;
  assign res_valid  = res_valid_q;
  assign res_x      = res_x_q;
  assign res_y      = res_y_q;
  assign res_z      = res_z_q;
  assign busy       = (state_q != IDLE);
  assign in_flight  = in_flight_q;

endmodule

// File: tb/tb_cordic_scheduler.sv
// ----------------------------------------------------------------------------
// tb_cordic_scheduler
//
// Directed bench for cordic_scheduler. A behavioural rotation-mode CORDIC
// with CORDIC_LATENCY stages of delay closes the loop. Each step predicts the
// grant from an independent round-robin/FSM model, pushes the expected result
// into a scoreboard on every transfer, and pops/compares when it falls due.
// ----------------------------------------------------------------------------
module tb_cordic_scheduler;

  localparam int N = 4;
  localparam int L = 14;

  typedef struct {
    int          ch;
    logic [15:0] x;
    logic [15:0] y;
    logic [4:0]  z;
    int          due;
  } exp_t;

  logic               clock = 1'b0;
  logic               reset;
  logic               enable;
  logic [3:0]         ch_mask, req_valid, req_ready, res_valid;
  logic signed [15:0] sx [4];
  logic signed [15:0] sy [4];
  logic [15:0]        sz [4];
  logic [63:0]        req_x, req_y, req_z;
  logic signed [15:0] cordic_xin, cordic_yin, cordic_xout, cordic_yout;
  logic [15:0]        cordic_zin;
  logic [4:0]         cordic_zout, res_z;
  logic signed [15:0] res_x, res_y;
  logic               busy;
  logic [3:0]         in_flight;

  assign req_x = {sx[3], sx[2], sx[1], sx[0]};
  assign req_y = {sy[3], sy[2], sy[1], sy[0]};
  assign req_z = {sz[3], sz[2], sz[1], sz[0]};

  always #5 clock = ~clock;

  cordic_scheduler #(
    .NUM_CH(N), .XY_WIDTH(16), .Z_INPUT_WIDTH(16), .Z_OUTPUT_WIDTH(5),
    .CORDIC_LATENCY(L)
  ) dut (
    .clock(clock), .reset(reset), .enable(enable), .ch_mask(ch_mask),
    .req_valid(req_valid), .req_ready(req_ready),
    .req_x(req_x), .req_y(req_y), .req_z(req_z),
    .cordic_xin(cordic_xin), .cordic_yin(cordic_yin), .cordic_zin(cordic_zin),
    .cordic_xout(cordic_xout), .cordic_yout(cordic_yout), .cordic_zout(cordic_zout),
    .res_valid(res_valid), .res_x(res_x), .res_y(res_y), .res_z(res_z),
    .busy(busy), .in_flight(in_flight)
  );

  // Phase scale: 65536 units per full turn.
  int atan_t [14];

  function automatic logic [36:0] cordic_fn(input int xi, input int yi, input int zi);
    int x, y, z, xn;
    x = xi; y = yi; z = zi;
    for (int i = 0; i < 14; i++) begin
      if (z >= 0) begin
        xn = x - (y >>> i); y = y + (x >>> i); x = xn; z = z - atan_t[i];
      end else begin
        xn = x + (y >>> i); y = y - (x >>> i); x = xn; z = z + atan_t[i];
      end
    end
    return {x[15:0], y[15:0], z[4:0]};
  endfunction

  logic [36:0] pipe [L];
  always @(posedge clock) begin
    pipe[0] <= cordic_fn(int'(cordic_xin), int'(cordic_yin), int'($signed(cordic_zin)));
    for (int i = 1; i < L; i++) pipe[i] <= pipe[i-1];
  end
  assign cordic_xout = pipe[L-1][36:21];
  assign cordic_yout = pipe[L-1][20:5];
  assign cordic_zout = pipe[L-1][4:0];

  // Reference model state
  exp_t               sb [$];
  int                 m_state;   // 0 IDLE, 1 RUN, 2 DRAIN
  int                 m_ptr, m_if, cyc;
  logic signed [15:0] m_rx, m_ry;
  logic [4:0]         m_rz;
  int                 grants [4];
  int                 max_if, n_push, n_pop;
  logic [3:0]         obs_ready;
  int                 n_chk, n_err;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_chk++;
    assert (obs === exp) else begin
      n_err++;
      $error("FAIL %s: observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic step();
    logic [3:0]  elig, exp_rdy, exp_rv;
    logic [36:0] r;
    int          g, c, nxt;
    logic        xfer, ex, en;
    exp_t        e;
    #1;
    elig = req_valid & ch_mask;
    exp_rdy = '0;
    g = -1;
    if (m_state == 1) begin
      for (int i = 0; i < N; i++) begin
        c = (m_ptr + i) % N;
        if (g < 0 && elig[c]) g = c;
      end
    end
    if (g >= 0) exp_rdy[g] = 1'b1;
    chk("req_ready", 32'(req_ready), 32'(exp_rdy));
    obs_ready = req_ready;
    xfer = (g >= 0);
    if (xfer) begin
      r = cordic_fn(int'(sx[g]), int'(sy[g]), int'($signed(sz[g])));
      e.ch = g; e.x = r[36:21]; e.y = r[20:5]; e.z = r[4:0]; e.due = cyc + 2 + L;
      sb.push_back(e);
      n_push++;
      grants[g]++;
      m_ptr = (g + 1) % N;
    end
    en = enable;
    @(posedge clock);
    #1;
    cyc++;
    exp_rv = '0;
    if (reset) begin
      nxt = m_state;
      case (m_state)
        0: if (en) nxt = 1;
        1: if (!en) nxt = 2;
        default: if (en) nxt = 1; else if (m_if == 0) nxt = 0;
      endcase
      m_state = nxt;
      ex = (sb.size() > 0) && (sb[0].due == cyc);
      m_if = m_if + (xfer ? 1 : 0) - (ex ? 1 : 0);
      if (ex) begin
        e = sb.pop_front();
        n_pop++;
        exp_rv[e.ch] = 1'b1;
        m_rx = e.x; m_ry = e.y; m_rz = e.z;
      end
    end
    chk("res_valid", 32'(res_valid), 32'(exp_rv));
    chk("res_x", 32'(res_x), 32'(m_rx));
    chk("res_y", 32'(res_y), 32'(m_ry));
    chk("res_z", 32'(res_z), 32'(m_rz));
    chk("in_flight", 32'(in_flight), 32'(m_if));
    chk("busy", 32'(busy), 32'(m_state != 0));
    if (int'(in_flight) > max_if) max_if = int'(in_flight);
    @(negedge clock);
  endtask

  task automatic check_zero_outputs(input string tag);
    chk({tag, "_req_ready"}, 32'(req_ready), 32'd0);
    chk({tag, "_res_valid"}, 32'(res_valid), 32'd0);
    chk({tag, "_busy"}, 32'(busy), 32'd0);
    chk({tag, "_in_flight"}, 32'(in_flight), 32'd0);
    chk({tag, "_cordic_in"}, {cordic_xin, cordic_yin}, 32'd0);
    chk({tag, "_cordic_zin"}, 32'(cordic_zin), 32'd0);
    chk({tag, "_res_xy"}, {res_x, res_y}, 32'd0);
    chk({tag, "_res_z"}, 32'(res_z), 32'd0);
  endtask

  task automatic model_reset();
    sb.delete();
    m_state = 0; m_ptr = 0; m_if = 0;
    m_rx = '0; m_ry = '0; m_rz = '0;
  endtask

  task automatic randomize_samples();
    for (int k = 0; k < N; k++) begin
      sx[k] = 16'(int'($urandom_range(0, 8000)) - 4000);
      sy[k] = 16'(int'($urandom_range(0, 8000)) - 4000);
      sz[k] = 16'(int'($urandom_range(0, 24576)) - 12288);
    end
  endtask

  initial begin
    logic [36:0] r0;
    for (int i = 0; i < 14; i++)
      atan_t[i] = int'($atan(1.0 / (2.0 ** i)) * 65536.0 / (2.0 * 3.14159265358979));
    n_chk = 0; n_err = 0; cyc = 0; max_if = 0; n_push = 0; n_pop = 0;
    for (int k = 0; k < N; k++) begin
      sx[k] = '0; sy[k] = '0; sz[k] = '0; grants[k] = 0;
    end
    model_reset();
    reset = 1'b0; enable = 1'b0; ch_mask = 4'hF; req_valid = 4'h0;
    #1;
    check_zero_outputs("reset");
    @(negedge clock);
    reset = 1'b1;
    step();

    // Single channel, enable sampled before any grant is possible
    enable = 1'b1;
    req_valid = 4'b0001;
    sx[0] = 16'sd1000; sy[0] = 16'sd0; sz[0] = 16'h2000;
    step();
    chk("no_grant_before_run", 32'(obs_ready), 32'd0);
    step();
    chk("single_grant", 32'(obs_ready), 32'b0001);
    req_valid = 4'b0000;
    r0 = cordic_fn(1000, 0, 8192);
    repeat (14) step();
    chk("single_not_early", 32'(res_valid), 32'd0);
    step();
    chk("single_res_valid", 32'(res_valid), 32'b0001);
    chk("single_res_xy", {res_x, res_y}, {r0[36:21], r0[20:5]});

    // Fairness across all four channels
    for (int k = 0; k < N; k++) grants[k] = 0;
    req_valid = 4'hF; ch_mask = 4'hF;
    for (int i = 0; i < 40; i++) begin
      randomize_samples();
      step();
    end
    for (int k = 0; k < N; k++) chk($sformatf("fair_grants_ch%0d", k), 32'(grants[k]), 32'd10);

    // Masking: only ch0 and ch2, pipe kept full
    for (int k = 0; k < N; k++) grants[k] = 0;
    ch_mask = 4'b0101; max_if = 0;
    for (int i = 0; i < 30; i++) begin
      randomize_samples();
      step();
    end
    chk("mask_grants_ch1_ch3", 32'(grants[1] + grants[3]), 32'd0);
    chk("mask_grants_ch0", 32'(grants[0]), 32'd15);
    chk("mask_inflight_max", 32'(max_if), 32'd15);
    req_valid = 4'h0;
    repeat (20) step();

    // Drain: enable falls on the fifth transfer, then no more grants
    ch_mask = 4'hF; req_valid = 4'hF;
    for (int i = 0; i < 4; i++) begin
      randomize_samples();
      step();
    end
    enable = 1'b0;
    randomize_samples();
    step();
    step();
    chk("drain_no_grant", 32'(obs_ready), 32'd0);
    chk("drain_busy", 32'(busy), 32'd1);
    req_valid = 4'h0;
    repeat (20) step();
    chk("drain_idle", {31'd0, busy}, 32'd0);
    chk("drain_inflight", 32'(in_flight), 32'd0);
    chk("drain_all_delivered", 32'(sb.size()), 32'd0);

    // Re-enable during DRAIN
    enable = 1'b1;
    step();
    req_valid = 4'hF;
    for (int i = 0; i < 4; i++) begin
      randomize_samples();
      step();
    end
    enable = 1'b0;
    repeat (2) step();
    enable = 1'b1;
    for (int i = 0; i < 3; i++) begin
      randomize_samples();
      step();
    end
    req_valid = 4'h0;
    repeat (20) step();
    chk("reenable_all_delivered", 32'(sb.size()), 32'd0);
    chk("reenable_push_pop", 32'(n_pop), 32'(n_push));

    // Reset in the middle of flight
    req_valid = 4'hF;
    for (int i = 0; i < 3; i++) begin
      randomize_samples();
      step();
    end
    req_valid = 4'h0;
    repeat (4) step();
    chk("pre_reset_inflight", 32'(in_flight), 32'd3);
    reset = 1'b0;
    enable = 1'b0;
    #1;
    check_zero_outputs("midreset");
    model_reset();
    @(negedge clock);
    step();
    reset = 1'b1;
    repeat (20) step();
    chk("post_reset_inflight", 32'(in_flight), 32'd0);

    $display("Result: errors=%0d of %0d checks", n_err, n_chk);
    $finish;
  end

endmodule
